muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit on the register-file read path.
- Consumes the two source-operand read values and the destination index from decode.
- Produces one result after a fixed 32-iteration computation, plus a one-cycle write strobe that drives the register file write port.
- `busy` stalls instruction fetch/decode while the operation is in flight.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_unit_operand_conditioner.sv | 31 +++
 rtl/muldiv_unit.sv | 129 ++++++++++++
 tb/tb_muldiv_unit.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } muldiv_state_t;

  // funct3[2] separates the divide/remainder group from the multiplies.
  function automatic logic is_divide(input muldiv_op_t op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_unit_operand_conditioner.sv
// Per-op sign extraction and absolute value of both operands, so the
// iterative datapath only ever works on unsigned magnitudes.
module operand_conditioner
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN
) (
  input  muldiv_op_t       op,
  input  logic [XLEN-1:0]  operand_a,
  input  logic [XLEN-1:0]  operand_b,
  output logic             sign_a,
  output logic             sign_b,
  output logic [XLEN-1:0]  mag_a,
  output logic [XLEN-1:0]  mag_b
);

  logic signed_a;
  logic signed_b;

  // NOTE: every always_comb output gets a value on every path; a missed
  // branch would silently infer a latch.
  always_comb begin
    signed_a = (op != OP_MULHU) && (op != OP_DIVU) && (op != OP_REMU);
    signed_b = signed_a && (op != OP_MULHSU);
    sign_a   = signed_a && operand_a[XLEN-1];
    sign_b   = signed_b && operand_b[XLEN-1];
    mag_a    = sign_a ? -operand_a : operand_a;
    mag_b    = sign_b ? -operand_b : operand_b;
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: one shift-add or restoring shift-subtract
// step per cycle for XLEN cycles, then a one-cycle done/write strobe.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN       = muldiv_pkg::XLEN,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [XLEN-1:0]       operand_a,
  input  logic [XLEN-1:0]       operand_b,
  input  logic [REG_ADDR_W-1:0] rd_in,
  output logic                  busy,
  output logic                  done,
  output logic [XLEN-1:0]       result,
  output logic [REG_ADDR_W-1:0] rd_out
);

  localparam int CNT_W = $clog2(XLEN);

  muldiv_state_t         state, state_next;
  muldiv_op_t            op_sel, op_q;
  logic [CNT_W-1:0]      count;
  logic [2*XLEN-1:0]     acc, acc_next, product;
  logic [XLEN-1:0]       mag_a_q, mag_b_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  neg_q, rem_neg_q, last_iter;
  logic                  cond_sign_a, cond_sign_b;
  logic [XLEN-1:0]       cond_mag_a, cond_mag_b;
  logic [XLEN:0]         mul_sum, div_hi;
  logic [XLEN-1:0]       div_diff, quotient, remainder, final_value;
  logic                  div_fits;

  assign op_sel    = muldiv_op_t'(op);
  assign last_iter = (count == CNT_W'(XLEN - 1));
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  operand_conditioner #(.XLEN(XLEN)) u_operand_conditioner (
    .op        (op_sel),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .sign_a    (cond_sign_a),
    .sign_b    (cond_sign_b),
    .mag_a     (cond_mag_a),
    .mag_b     (cond_mag_b)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = CALC;
      CALC:    if (last_iter) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Multiply keeps {partial, multiplier} in acc; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mag_a_q} : '0);
    div_hi   = acc[2*XLEN-1:XLEN-1];
    div_fits = (div_hi >= {1'b0, mag_b_q});
    div_diff = div_hi[XLEN-1:0] - mag_b_q;
    if (is_divide(op_q))
      acc_next = {(div_fits ? div_diff : div_hi[XLEN-1:0]), acc[XLEN-2:0], div_fits};
    else
      acc_next = {mul_sum, acc[XLEN-1:1]};

    product   = neg_q ? -acc_next : acc_next;
    quotient  = (mag_b_q == '0) ? '1 :
                (neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0]);
    remainder = rem_neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

    case (op_q)
      OP_MUL:                       final_value = product[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: final_value = product[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              final_value = quotient;
      default:                      final_value = remainder;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= OP_MUL;
      count     <= '0;
      acc       <= '0;
      mag_a_q   <= '0;
      mag_b_q   <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      rd_q      <= '0;
      result    <= '0;
      rd_out    <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          op_q      <= op_sel;
          rd_q      <= rd_in;
          mag_a_q   <= cond_mag_a;
          mag_b_q   <= cond_mag_b;
          neg_q     <= cond_sign_a ^ cond_sign_b;
          rem_neg_q <= cond_sign_a;
          count     <= '0;
          acc       <= is_divide(op_sel) ? {{XLEN{1'b0}}, cond_mag_a}
                                         : {{XLEN{1'b0}}, cond_mag_b};
        end
        CALC: begin
          acc   <= acc_next;
          count <= count + 1'b1;
          // Result is registered on the last step so it is stable throughout DONE.
          if (last_iter) begin
            result <= final_value;
            rd_out <= rd_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, multi-cycle
// corner sequences and random ops against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] operand_a, operand_b;
  logic [4:0]  rd_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  rd_out;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[15];

  muldiv_unit #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .operand_a (operand_a),
    .operand_b (operand_b),
    .rd_in     (rd_in),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint      sa, sb, ua, ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'b0, a});
    ub = longint'({32'b0, b});
    case (o)
      3'd0: begin p = 64'(sa * sb); return p[31:0];  end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin if (b == 0) return '1; p = 64'(sa / sb); return p[31:0]; end
      3'd5: begin if (b == 0) return '1; p = 64'(ua / ub); return p[31:0]; end
      3'd6: begin if (b == 0) return a;  p = 64'(sa % sb); return p[31:0]; end
      default: begin if (b == 0) return a; p = 64'(ua % ub); return p[31:0]; end
    endcase
  endfunction

  // Called at a negedge; start is seen on the next posedge (cycle N).
  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic [31:0] exp,
                        input bit perturb);
    int done_cnt = 0;
    int done_at  = -1;
    bit busy_ok  = 1'b1;
    op = o; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (busy !== (k <= 33)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        done_cnt++;
        done_at = k;
      end
      if (k == 33) begin
        check({name, " result"}, result, exp);
        check({name, " rd_out"}, rd_out, rd);
      end
      if (perturb && k <= 20) begin
        start = 1'b1; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
        rd_in = 5'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    check({name, " done_count"}, done_cnt, 1);
    check({name, " done_cycle"}, done_at, 33);
    check({name, " busy_window"}, busy_ok, 1'b1);
  endtask

  initial begin
    vecs[0]  = '{3'd0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB};
    vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vecs[4]  = '{3'd4, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFA};
    vecs[5]  = '{3'd6, 32'hFFFF_FFEC, 32'd3,         32'hFFFF_FFFE};
    vecs[6]  = '{3'd5, 32'd20,        32'd3,         32'd6};
    vecs[7]  = '{3'd7, 32'd20,        32'd3,         32'd2};
    vecs[8]  = '{3'd4, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[9]  = '{3'd7, 32'd5,         32'd0,         32'd5};
    vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};
    vecs[12] = '{3'd5, 32'd5,         32'd0,         32'hFFFF_FFFF};
    vecs[13] = '{3'd6, 32'hFFFF_FFEC, 32'd0,         32'hFFFF_FFEC};
    vecs[14] = '{3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780};

    rst = 1'b1; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; rd_in = '0;
    repeat (2) @(negedge clk);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset result", result, 32'd0);
    check("reset rd_out", rd_out, 5'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mul_latency", 3'd0, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB, 1'b0);

    for (int i = 0; i < 15; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             5'(i + 3), vecs[i].exp, 1'b0);

    run_op("isolation", 3'd5, 32'd100, 32'd7, 5'd17, 32'd14, 1'b1);

    // Reset in cycle N+10 of a multiply.
    begin
      bit saw_done = 1'b0;
      op = 3'd0; operand_a = 32'd1000; operand_b = 32'd1000; rd_in = 5'd8; start = 1'b1;
      @(posedge clk);
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        start = 1'b0;
        if (done === 1'b1) saw_done = 1'b1;
        if (k == 10) rst = 1'b1;
      end
      @(negedge clk);
      if (done === 1'b1) saw_done = 1'b1;
      check("midreset busy", busy, 1'b0);
      check("midreset result", result, 32'd0);
      check("midreset rd_out", rd_out, 5'd0);
      check("midreset no_done", saw_done, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      run_op("after_reset", 3'd0, 32'd3, 32'd4, 5'd9, 32'd12, 1'b0);
    end

    run_op("rd_zero", 3'd7, 32'd9, 32'd4, 5'd0, 32'd1, 1'b0);

    for (int i = 0; i < 24; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom);
      ra = $urandom;
      rb = (i % 6 == 5) ? 32'd0 : ((i % 4 == 3) ? 32'($urandom_range(1, 255)) : $urandom);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb, 5'($urandom), ref_model(ro, ra, rb), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
